// File: rtl/lsu_axi.sv
// Load/store unit: one AXI-lite read or write per decoded load/store strobe.
// Returns aligned, extended load data and stalls the PC via lsu_busy.
module lsu_axi #(
  parameter logic [2:0]  DPORT   = 3'b000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lb,
  input  logic        lh,
  input  logic        lw,
  input  logic        ld,
  input  logic        lbu,
  input  logic        lhu,
  input  logic        lwu,
  input  logic        sb,
  input  logic        sh,
  input  logic        sw,
  input  logic        sd,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [63:0] lsu_rdata,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [63:0] ARADDR,
  output logic [2:0]  ARPORT,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [63:0] RDATA,
  input  logic [1:0]  RRESP,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [63:0] AWADDR,
  output logic [2:0]  AWPORT,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [63:0] WDATA,
  output logic [7:0]  WSTRB,
  input  logic        BVALID,
  output logic        BREADY,
  input  logic [1:0]  BRESP
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR_AW, WR_B, FIN
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [2:0]  off_q;
  logic [31:0] cnt;
  logic        aw_done;
  logic        w_done;

  logic [10:0] stb;
  logic        one_hot;
  logic [1:0]  r_size;
  logic        r_sgn;
  logic        r_ld;
  logic [2:0]  r_amask;
  logic [7:0]  r_strb;
  logic        r_bad;

  assign stb = {sd, sw, sh, sb, lwu, lhu,
                lbu, ld, lw, lh, lb};
  assign one_hot = ($countones(stb) == 1);

  always_comb begin
    r_size = 2'd0;
    r_sgn  = 1'b0;
    r_ld   = 1'b0;
    if (one_hot) begin
      unique case (1'b1)
        lb:  begin r_ld = 1'b1; r_sgn = 1'b1; end
        lh:  begin r_ld = 1'b1; r_sgn = 1'b1;
                   r_size = 2'd1; end
        lw:  begin r_ld = 1'b1; r_sgn = 1'b1;
                   r_size = 2'd2; end
        ld:  begin r_ld = 1'b1; r_size = 2'd3; end
        lbu: r_ld = 1'b1;
        lhu: begin r_ld = 1'b1; r_size = 2'd1; end
        lwu: begin r_ld = 1'b1; r_size = 2'd2; end
        sb:  r_size = 2'd0;
        sh:  r_size = 2'd1;
        sw:  r_size = 2'd2;
        sd:  r_size = 2'd3;
        default: r_size = 2'd0;
      endcase
    end
  end

  always_comb begin
    r_amask = 3'b000;
    r_strb  = 8'h01;
    unique case (r_size)
      2'd0: begin r_amask = 3'b000; r_strb = 8'h01; end
      2'd1: begin r_amask = 3'b001; r_strb = 8'h03; end
      2'd2: begin r_amask = 3'b011; r_strb = 8'h0F; end
      2'd3: begin r_amask = 3'b111; r_strb = 8'hFF; end
      default: r_amask = 3'b000;
    endcase
  end

  assign r_bad = !one_hot || (|(addr[2:0] & r_amask));

  logic [63:0] rsh;
  logic [63:0] ext;

  assign rsh = RDATA >> {off_q, 3'b000};

  always_comb begin
    ext = rsh;
    unique case (size_q)
      2'd0: ext = sgn_q ? {{56{rsh[7]}}, rsh[7:0]}
                        : {56'd0, rsh[7:0]};
      2'd1: ext = sgn_q ? {{48{rsh[15]}}, rsh[15:0]}
                        : {48'd0, rsh[15:0]};
      2'd2: ext = sgn_q ? {{32{rsh[31]}}, rsh[31:0]}
                        : {32'd0, rsh[31:0]};
      2'd3: ext = rsh;
      default: ext = rsh;
    endcase
  end

  logic tmo;
  logic aw_hs;
  logic w_hs;
  logic aw_ok;
  logic w_ok;

  // TIMEOUT of zero disables the abort path entirely
  assign tmo   = (TIMEOUT != 0) &&
                 (cnt + 32'd1 == 32'(TIMEOUT));
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done | w_hs;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      size_q    <= 2'd0;
      sgn_q     <= 1'b0;
      off_q     <= 3'd0;
      cnt       <= 32'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      lsu_busy  <= 1'b0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= 64'd0;
      ARVALID   <= 1'b0;
      ARADDR    <= 64'd0;
      ARPORT    <= 3'd0;
      RREADY    <= 1'b0;
      AWVALID   <= 1'b0;
      AWADDR    <= 64'd0;
      AWPORT    <= 3'd0;
      WVALID    <= 1'b0;
      WDATA     <= 64'd0;
      WSTRB     <= 8'd0;
      BREADY    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|stb) begin
            size_q   <= r_size;
            sgn_q    <= r_sgn;
            off_q    <= addr[2:0];
            cnt      <= 32'd0;
            lsu_busy <= 1'b1;
            lsu_err  <= 1'b0;
            if (r_bad) begin
              state    <= FIN;
              lsu_done <= 1'b1;
              lsu_err  <= 1'b1;
            end else if (r_ld) begin
              state   <= RD_A;
              ARVALID <= 1'b1;
              ARADDR  <= addr;
              ARPORT  <= DPORT;
            end else begin
              state   <= WR_AW;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              AWADDR  <= addr;
              AWPORT  <= DPORT;
              WDATA   <= wdata << {addr[2:0], 3'b000};
              WSTRB   <= r_strb << addr[2:0];
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end
          end
        end
        RD_A: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            cnt     <= 32'd0;
            state   <= RD_D;
          end else if (tmo) begin
            ARVALID  <= 1'b0;
            lsu_err  <= 1'b1;
            lsu_done <= 1'b1;
            state    <= FIN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RD_D: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            lsu_rdata <= ext;
            lsu_err   <= |RRESP;
            lsu_done  <= 1'b1;
            state     <= FIN;
          end else if (tmo) begin
            RREADY   <= 1'b0;
            lsu_err  <= 1'b1;
            lsu_done <= 1'b1;
            state    <= FIN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WR_AW: begin
          if (aw_hs) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            BREADY <= 1'b1;
            cnt    <= 32'd0;
            state  <= WR_B;
          end else if (tmo) begin
            AWVALID  <= 1'b0;
            WVALID   <= 1'b0;
            lsu_err  <= 1'b1;
            lsu_done <= 1'b1;
            state    <= FIN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WR_B: begin
          if (BVALID) begin
            BREADY   <= 1'b0;
            lsu_err  <= |BRESP;
            lsu_done <= 1'b1;
            state    <= FIN;
          end else if (tmo) begin
            BREADY   <= 1'b0;
            lsu_err  <= 1'b1;
            lsu_done <= 1'b1;
            state    <= FIN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        FIN: begin
          lsu_done <= 1'b0;
          lsu_err  <= 1'b0;
          lsu_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi.sv
// Randomised bench for lsu_axi: per-transaction timeline model
// derived from handshake cycles, checked every cycle.
module tb_lsu_axi;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [10:0] stb = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [63:0] lsu_rdata;
  logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
  logic        ARREADY = 1'b0, RVALID = 1'b0;
  logic        AWREADY = 1'b0, WREADY = 1'b0;
  logic        BVALID = 1'b0;
  logic [63:0] ARADDR, AWADDR, WDATA;
  logic [2:0]  ARPORT, AWPORT;
  logic [7:0]  WSTRB;
  logic [63:0] RDATA = '0;
  logic [1:0]  RRESP = '0, BRESP = '0;

  lsu_axi #(.DPORT(3'b000), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .lb(stb[0]), .lh(stb[1]), .lw(stb[2]),
    .ld(stb[3]), .lbu(stb[4]), .lhu(stb[5]),
    .lwu(stb[6]), .sb(stb[7]), .sh(stb[8]),
    .sw(stb[9]), .sd(stb[10]),
    .addr(addr), .wdata(wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done),
    .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARPORT(ARPORT),
    .RVALID(RVALID), .RREADY(RREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWADDR(AWADDR), .AWPORT(AWPORT),
    .WVALID(WVALID), .WREADY(WREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY),
    .BRESP(BRESP)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int tid = 0;
  logic [63:0] cur_rd = '0;
  bit rd_known = 1'b1;

  int cap_done_c, arv_n, awv_last, wv_last;
  logic cap_err;
  logic [63:0] cap_rdata, cap_wdata;
  logic [7:0] cap_wstrb;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cb(input string nm, input logic a, input logic e);
    chk(nm, {63'd0, a}, {63'd0, e});
  endtask

  task automatic chk_zero(input string tg);
    cb({tg, " busy"}, lsu_busy, 1'b0);
    cb({tg, " done"}, lsu_done, 1'b0);
    cb({tg, " err"}, lsu_err, 1'b0);
    chk({tg, " rdata"}, lsu_rdata, 64'd0);
    cb({tg, " arvalid"}, ARVALID, 1'b0);
    cb({tg, " rready"}, RREADY, 1'b0);
    cb({tg, " awvalid"}, AWVALID, 1'b0);
    cb({tg, " wvalid"}, WVALID, 1'b0);
    cb({tg, " bready"}, BREADY, 1'b0);
    chk({tg, " araddr"}, ARADDR, 64'd0);
    chk({tg, " awaddr"}, AWADDR, 64'd0);
    chk({tg, " wdata"}, WDATA, 64'd0);
    chk({tg, " wstrb"}, {56'd0, WSTRB}, 64'd0);
    chk({tg, " ports"}, {58'd0, ARPORT, AWPORT}, 64'd0);
  endtask

  function automatic int sz_of(input int op);
    case (op)
      1, 5, 8: return 1;
      2, 6, 9: return 2;
      3, 10:   return 3;
      default: return 0;
    endcase
  endfunction

  // Extension done arithmetically: a negative value is the
  // masked field minus 2**width.
  function automatic logic [63:0] ext_of(input int op,
      input logic [63:0] rd, input logic [2:0] off);
    logic [63:0] v, b, h, w;
    v = rd >> (8 * off);
    b = v & 64'hFF;
    h = v & 64'hFFFF;
    w = v & 64'hFFFF_FFFF;
    case (op)
      0: return v[7]  ? b - 64'h100 : b;
      1: return v[15] ? h - 64'h1_0000 : h;
      2: return v[31] ? w - 64'h1_0000_0000 : w;
      4: return b;
      5: return h;
      6: return w;
      default: return v;
    endcase
  endfunction

  function automatic bit inr(input int c, input int lo,
                             input int hi);
    return c >= lo && c <= hi;
  endfunction

  // ta/tw/tc: cycles (relative to the strobe) at which the slave
  // pulses AR- or AW-ready, R-valid or W-ready, and B-valid.
  task automatic run_txn(input logic [10:0] s,
      input logic [63:0] ad, input logic [63:0] wd,
      input logic [63:0] rd, input logic [1:0] rsp,
      input int ta, input int tw, input int tc,
      input int rst_at);
    int op, sz, done_c, m, last;
    int arv_e, rr_l, rr_h, awv_e, wv_e, br_l, br_h;
    bit ld_op, bad, e_err, upd, nk;
    logic [63:0] newv, xw;
    logic [7:0] xs;
    string tg;
    op = 0;
    for (int i = 10; i >= 0; i--) if (s[i]) op = i;
    sz = sz_of(op);
    ld_op = (op < 7);
    bad = ($countones(s) != 1) ||
          ((int'(ad[2:0]) % (1 << sz)) != 0);
    xw = wd << (8 * ad[2:0]);
    xs = 8'(((1 << (1 << sz)) - 1) << ad[2:0]);
    newv = ext_of(op, rd, ad[2:0]);
    arv_e = 0; rr_l = 1; rr_h = 0;
    awv_e = 0; wv_e = 0; br_l = 1; br_h = 0;
    upd = 0; nk = 0; e_err = 1; done_c = 1;
    if (bad) begin
      done_c = 1;
    end else if (ld_op) begin
      if (ta > TO) begin
        arv_e = TO; done_c = TO + 1;
      end else begin
        arv_e = ta; rr_l = ta + 1;
        if (tw > ta + TO) begin
          rr_h = ta + TO; done_c = ta + TO + 1;
        end else begin
          rr_h = tw; done_c = tw + 1;
          e_err = (rsp != 0); upd = 1; nk = (rsp == 0);
        end
      end
    end else begin
      m = (ta > tw) ? ta : tw;
      if (m > TO) begin
        awv_e = (ta < TO) ? ta : TO;
        wv_e  = (tw < TO) ? tw : TO;
        done_c = TO + 1;
      end else begin
        awv_e = ta; wv_e = tw; br_l = m + 1;
        if (tc > m + TO) begin
          br_h = m + TO; done_c = m + TO + 1;
        end else begin
          br_h = tc; done_c = tc + 1; e_err = (rsp != 0);
        end
      end
    end
    last = (rst_at > 0) ? rst_at + 1 : done_c;
    cap_done_c = -1; cap_err = 0; arv_n = 0;
    awv_last = 0; wv_last = 0;
    cap_rdata = '0; cap_wdata = '0; cap_wstrb = '0;
    tid++;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      tg = $sformatf("t%0d c%0d", tid, c);
      if (rst_at > 0 && c == rst_at + 1) begin
        chk_zero(tg);
        cur_rd = '0; rd_known = 1;
      end else begin
        cb({tg, " busy"}, lsu_busy, inr(c, 1, done_c));
        cb({tg, " done"}, lsu_done, c == done_c);
        if (c == done_c) cb({tg, " err"}, lsu_err, e_err);
        cb({tg, " arvalid"}, ARVALID, inr(c, 1, arv_e));
        cb({tg, " rready"}, RREADY, inr(c, rr_l, rr_h));
        cb({tg, " awvalid"}, AWVALID, inr(c, 1, awv_e));
        cb({tg, " wvalid"}, WVALID, inr(c, 1, wv_e));
        cb({tg, " bready"}, BREADY, inr(c, br_l, br_h));
        if (inr(c, 1, arv_e)) begin
          chk({tg, " araddr"}, ARADDR, ad);
          chk({tg, " arport"}, {61'd0, ARPORT}, 64'd0);
        end
        if (inr(c, 1, awv_e)) begin
          chk({tg, " awaddr"}, AWADDR, ad);
          chk({tg, " awport"}, {61'd0, AWPORT}, 64'd0);
        end
        if (inr(c, 1, wv_e)) begin
          chk({tg, " wdata"}, WDATA, xw);
          chk({tg, " wstrb"}, {56'd0, WSTRB}, {56'd0, xs});
        end
        if (c >= done_c && upd) begin
          if (nk) chk({tg, " rdata"}, lsu_rdata, newv);
        end else if (rd_known) begin
          chk({tg, " rdata"}, lsu_rdata, cur_rd);
        end
      end
      if (lsu_done) begin
        cap_done_c = c; cap_err = lsu_err;
        cap_rdata = lsu_rdata;
      end
      if (ARVALID) arv_n++;
      if (AWVALID) awv_last = c;
      if (WVALID) wv_last = c;
      if (c == 1) begin
        cap_wdata = WDATA; cap_wstrb = WSTRB;
      end
      rstn  = !(rst_at > 0 && c == rst_at);
      stb   = (c == 0) ? s : '0;
      addr  = (c == 0) ? ad : {$urandom, $urandom};
      wdata = (c == 0) ? wd : {$urandom, $urandom};
      ARREADY = !bad && ld_op && c == ta;
      RVALID  = !bad && ld_op && c == tw;
      RDATA   = (c == tw) ? rd : {$urandom, $urandom};
      RRESP   = rsp;
      AWREADY = !bad && !ld_op && c == ta;
      WREADY  = !bad && !ld_op && c == tw;
      BVALID  = !bad && !ld_op && c == tc;
      BRESP   = rsp;
    end
    if (rst_at == 0 && upd) begin
      cur_rd = newv; rd_known = nk;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cb("idle busy", lsu_busy, 1'b0);
      cb("idle done", lsu_done, 1'b0);
      stb = '0; ARREADY = 0; RVALID = 0;
      AWREADY = 0; WREADY = 0; BVALID = 0;
    end
  endtask

  function automatic int dly();
    int p;
    p = $urandom_range(0, 24);
    if (p == 0) return TO;
    if (p == 1) return TO + 1;
    return $urandom_range(1, 3);
  endfunction

  initial begin
    int op, sz, ta, tw, tc;
    logic [10:0] s;
    logic [63:0] ad;
    logic [1:0] rsp;
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("reset a");
    @(negedge clk);
    chk_zero("reset b");
    rstn = 1'b1;

    run_txn(11'h001, 64'h8000_0003,
            64'h0, 64'h0000_0000_8000_0000,
            2'b00, 1, 2, 0, 0);
    chk("lb done cycle", 64'(cap_done_c), 64'd3);
    cb("lb err", cap_err, 1'b0);
    chk("lb rdata", cap_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    run_txn(11'h100, 64'h8000_0006,
            64'hABCD_1234, 64'h0, 2'b00, 1, 4, 5, 0);
    chk("sh wdata", cap_wdata, 64'h1234_0000_0000_0000);
    chk("sh wstrb", {56'd0, cap_wstrb}, 64'hC0);
    chk("sh awvalid last", 64'(awv_last), 64'd1);
    chk("sh wvalid last", 64'(wv_last), 64'd4);
    chk("sh done cycle", 64'(cap_done_c), 64'd6);

    run_txn(11'h004, 64'h8000_0002,
            64'h0, 64'h0, 2'b00, 1, 2, 0, 0);
    chk("lw mis arvalid n", 64'(arv_n), 64'd0);
    chk("lw mis done cycle", 64'(cap_done_c), 64'd1);
    cb("lw mis err", cap_err, 1'b1);

    run_txn(11'h008, 64'h8000_0008,
            64'h0, 64'h1122_3344_5566_7788,
            2'b10, 11, 12, 0, 0);
    chk("ld slverr done cycle", 64'(cap_done_c), 64'd13);
    cb("ld slverr err", cap_err, 1'b1);

    run_txn(11'h004, 64'h8000_0010,
            64'h0, 64'h0, 2'b00, 1000, 1001, 0, 0);
    chk("tmo arvalid n", 64'(arv_n), 64'd12);
    chk("tmo done cycle", 64'(cap_done_c), 64'd13);
    cb("tmo err", cap_err, 1'b1);

    run_txn(11'h004, 64'h8000_0020,
            64'h0, 64'h0, 2'b00, 1, 50, 0, 3);
    chk("rst no done", 64'(cap_done_c), 64'hFFFF_FFFF_FFFF_FFFF);
    run_txn(11'h040, 64'h8000_0024,
            64'h0, 64'hF123_4567_0000_0000,
            2'b00, 1, 2, 0, 0);
    chk("lwu rdata", cap_rdata, 64'h0000_0000_F123_4567);
    chk("lwu done cycle", 64'(cap_done_c), 64'd3);

    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 10);
      sz = sz_of(op);
      s = 11'(1 << op);
      if ($urandom_range(0, 9) == 0)
        s = s | 11'(1 << $urandom_range(0, 10));
      ad = {32'h0, 32'h8000_0000 | $urandom};
      if ($urandom_range(0, 3) != 0)
        ad = ad & ~64'((1 << sz) - 1);
      rsp = ($urandom_range(0, 5) == 0) ?
            2'($urandom_range(1, 3)) : 2'b00;
      ta = dly();
      if (op < 7) begin
        tw = ta + dly(); tc = 0;
      end else begin
        tw = dly();
        tc = ((ta > tw) ? ta : tw) + dly();
      end
      run_txn(s, ad, {$urandom, $urandom},
              {$urandom, $urandom}, rsp, ta, tw, tc, 0);
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 2));
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
